// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: producer side of the IF/ID interface.
// Owns the PC, fetches from instruction memory over a req/ack handshake,
// and presents {instruction, PC+4, valid} to IF/ID, which samples on the
// falling edge. All state changes happen on the rising edge only.
// Honours stall (hold outputs) and redirect (flush, refetch at target,
// discard any response still in flight).
// Optional macro IF_PERF_COUNT_EN adds perf_fetched / perf_discarded.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrucao_out,
  output logic [31:0] pc_somado_out,
`ifdef IF_PERF_COUNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
`endif
  output logic        valid_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic        w_done;
  logic [31:0] w_target;
  logic [31:0] w_addr_inc;
  logic [31:0] w_discard_pc;

  // Request is a pure decode of the registered state, so it is stable all cycle.
  assign imem_req      = (r_state == FETCH) || (r_state == DISCARD);
  assign imem_addr     = r_addr & ALIGN_MASK;
  assign w_done        = imem_req && imem_ack;
  assign w_target      = redirect_pc & ALIGN_MASK;
  assign w_addr_inc    = (r_addr & ALIGN_MASK) + 32'd4;
  // While discarding, a redirect only retargets where fetching resumes.
  assign w_discard_pc  = redirect ? w_target : r_pc;

  assign instrucao_out = r_instr;
  assign pc_somado_out = r_pc4;
  assign valid_out     = r_valid;

  // Fetch FSM: state, PC, request address and the registered IF/ID outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC & ALIGN_MASK;
      r_addr  <= RESET_PC & ALIGN_MASK;
      r_instr <= NOP_WORD;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      // A redirect flushes the outputs in every state, even under stall;
      // otherwise a consumed edge with nothing new presents a bubble.
      if (redirect || !stall) begin
        r_instr <= NOP_WORD;
        r_pc4   <= 32'd0;
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          if (redirect) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end else begin
            r_addr <= r_pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            r_pc <= w_target;
            // A response landing on the redirect edge is simply dropped;
            // otherwise the old request must still be drained first.
            if (w_done) begin
              r_addr  <= w_target;
              r_state <= FETCH;
            end else begin
              r_state <= DISCARD;
            end
          end else if (w_done) begin
            r_pc <= w_addr_inc;
            if (!stall) begin
              r_instr <= imem_rdata;
              r_pc4   <= w_addr_inc;
              r_valid <= 1'b1;
              r_addr  <= w_addr_inc;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_state <= FETCH;
          end else if (!stall) begin
            r_instr <= r_buf_instr;
            r_pc4   <= r_buf_pc4;
            r_valid <= 1'b1;
            r_addr  <= r_pc;
            r_state <= FETCH;
          end
        end
        DISCARD: begin
          r_pc <= w_discard_pc;
          if (w_done) begin
            r_addr  <= w_discard_pc;
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hold buffer captures a response that arrives while IF/ID is stalled.
  always_ff @(posedge clock) begin
    if (r_state == FETCH && w_done && stall && !redirect) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc4   <= w_addr_inc;
    end
  end

`ifdef IF_PERF_COUNT_EN
  logic w_load_valid;
  logic w_drop;

  assign w_load_valid = !redirect && !stall &&
                        ((r_state == FETCH && w_done) || (r_state == HOLD));
  assign w_drop       = w_done &&
                        ((r_state == DISCARD) || (r_state == FETCH && redirect));

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched   <= 32'd0;
      perf_discarded <= 32'd0;
    end else begin
      if (w_load_valid) perf_fetched   <= perf_fetched + 32'd1;
      if (w_drop)       perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: memory model with variable latency,
// directed scenarios, then randomized stall/redirect/latency traffic
// checked against an in-order instruction stream scoreboard.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrucao_out;
  logic [31:0] pc_somado_out;
  logic        valid_out;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
  int          m_fetched;
  logic [31:0] disc_base;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  int          wcnt;
  int          idle_cnt;
  logic [31:0] exp_pc;

  instruction_fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instrucao_out (instrucao_out),
    .pc_somado_out (pc_somado_out),
`ifdef IF_PERF_COUNT_EN
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded),
`endif
    .valid_out     (valid_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Memory: acks after the request has waited 'lat' cycles.
  always_comb begin
    imem_ack   = imem_req && (wcnt >= lat);
    imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock with the given controls; scoreboard checks every edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic        p_req, p_ack, p_valid, p_stall, p_rd;
    logic [31:0] p_addr, p_instr, p_pc4;
    stall = st; redirect = rd; redirect_pc = rpc;
    @(negedge clock);
    p_req = imem_req; p_ack = imem_ack; p_valid = valid_out;
    p_stall = stall; p_rd = redirect; p_addr = imem_addr;
    p_instr = instrucao_out; p_pc4 = pc_somado_out;
    @(posedge clock); #1;
    if (p_req) chk("addr_align", {62'd0, p_addr[1:0]}, 64'd0);
    if (p_req && !p_ack && imem_req) chk("addr_stable", {32'd0, imem_addr}, {32'd0, p_addr});
    if (p_rd) begin
      chk("flush_valid", {63'd0, valid_out}, 64'd0);
      exp_pc = rpc & 32'hFFFF_FFFC;
      idle_cnt = 0;
    end else if (p_stall) begin
      chk("hold_data", {instrucao_out, pc_somado_out}, {p_instr, p_pc4});
      chk("hold_valid", {63'd0, valid_out}, {63'd0, p_valid});
      idle_cnt = 0;
    end else if (p_valid) begin
      chk("instr", {32'd0, p_instr}, {32'd0, memf(exp_pc)});
      chk("pc4", {32'd0, p_pc4}, {32'd0, exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (idle_cnt > 20) begin
        chk("progress", 64'(idle_cnt), 64'd0);
        idle_cnt = 0;
      end
    end
`ifdef IF_PERF_COUNT_EN
    if (valid_out && !p_stall) m_fetched++;
    chk("perf_fetched", {32'd0, perf_fetched}, 64'(unsigned'(m_fetched)));
`endif
    if (p_req && p_ack) wcnt = 0;
    else if (p_req) wcnt++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, {32'd0, instrucao_out}, 64'd0);
    chk({tag, "_pc4"},   {32'd0, pc_somado_out}, 64'd0);
    chk({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
    chk({tag, "_req"},   {63'd0, imem_req}, 64'd0);
    chk({tag, "_addr"},  {32'd0, imem_addr}, 64'd0);
`ifdef IF_PERF_COUNT_EN
    chk({tag, "_perf"},  {perf_fetched, perf_discarded}, 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    lat = 0; wcnt = 0; idle_cnt = 0; exp_pc = 32'd0;
`ifdef IF_PERF_COUNT_EN
    m_fetched = 0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    // Zero-wait start: IDLE->FETCH, first valid on the 2nd edge.
    step(0, 0, 0);
    chk("e1_valid", {63'd0, valid_out}, 64'd0);
    chk("e1_req", {63'd0, imem_req}, 64'd1);
    chk("e1_addr", {32'd0, imem_addr}, 64'd0);
    step(0, 0, 0);
    chk("e2_valid", {63'd0, valid_out}, 64'd1);
    chk("e2_pc4", {32'd0, pc_somado_out}, 64'd4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("zw_addr", {32'd0, imem_addr}, 64'(32'd8 + 32'(i) * 4));
      chk("zw_pc4", {32'd0, pc_somado_out}, 64'(32'd8 + 32'(i) * 4));
    end

    // Latency 3 at 0x100.
    step(0, 1, 32'h100);
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("lat_addr", {32'd0, imem_addr}, 64'h100);
      chk("lat_valid", {63'd0, valid_out}, 64'd0);
    end
    step(0, 0, 0);
    chk("lat_done_valid", {63'd0, valid_out}, 64'd1);
    chk("lat_done_pc4", {32'd0, pc_somado_out}, 64'h104);
    step(0, 0, 0);
    chk("lat_bubble", {63'd0, valid_out}, 64'd0);

    // Stall with a response in hand: hold outputs, no request.
    lat = 0;
    step(0, 1, 32'h1C);
    step(0, 0, 0);
    chk("st_pc4_a", {32'd0, pc_somado_out}, 64'h20);
    step(1, 0, 0);
    chk("st_req_a", {63'd0, imem_req}, 64'd0);
    step(1, 0, 0);
    chk("st_req_b", {63'd0, imem_req}, 64'd0);
    chk("st_pc4_b", {32'd0, pc_somado_out}, 64'h20);
    step(0, 0, 0);
    chk("st_rel_pc4", {32'd0, pc_somado_out}, 64'h24);
    chk("st_rel_addr", {32'd0, imem_addr}, 64'h24);
    step(0, 0, 0);
    chk("st_next_pc4", {32'd0, pc_somado_out}, 64'h28);

    // Redirect while 0x40 is outstanding: drain and drop it.
    step(0, 1, 32'h40);
    lat = 3;
    step(0, 0, 0);
`ifdef IF_PERF_COUNT_EN
    disc_base = perf_discarded;
`endif
    step(0, 1, 32'h400);
    chk("dis_req", {63'd0, imem_req}, 64'd1);
    chk("dis_addr", {32'd0, imem_addr}, 64'h40);
    for (int i = 0; i < 8 && imem_addr != 32'h400; i++) begin
      step(0, 0, 0);
      chk("dis_valid", {63'd0, valid_out}, 64'd0);
    end
    chk("dis_new_addr", {32'd0, imem_addr}, 64'h400);
`ifdef IF_PERF_COUNT_EN
    chk("dis_perf", {32'd0, perf_discarded - disc_base}, 64'd1);
`endif
    lat = 0;
    step(0, 0, 0);
    chk("dis_pc4", {32'd0, pc_somado_out}, 64'h404);
    chk("dis_instr", {32'd0, instrucao_out}, {32'd0, memf(32'h400)});

    // Redirect and stall together: flush wins.
    step(1, 1, 32'h300);
    chk("rs_valid", {63'd0, valid_out}, 64'd0);
    chk("rs_addr", {32'd0, imem_addr}, 64'h300);
    step(0, 0, 0);
    chk("rs_pc4", {32'd0, pc_somado_out}, 64'h304);

    // Wrap at the top of the address space; low target bits are ignored.
    step(0, 1, 32'hFFFF_FFFE);
    chk("wr_addr", {32'd0, imem_addr}, 64'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wr_pc4", {32'd0, pc_somado_out}, 64'd0);
    chk("wr_valid", {63'd0, valid_out}, 64'd1);
    chk("wr_next", {32'd0, imem_addr}, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) lat = $urandom_range(3);
      step(($urandom_range(3) == 0), ($urandom_range(19) == 0), $urandom & 32'h0000_FFFF);
    end

    // Reset in the middle of an outstanding request.
    lat = 3;
    step(0, 1, 32'h800);
    step(0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(posedge clock); #1;
    chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
    reset = 1'b0;
    wcnt = 0; lat = 0; exp_pc = 32'd0; idle_cnt = 0;
`ifdef IF_PERF_COUNT_EN
    m_fetched = 0;
`endif
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_rst_valid", {63'd0, valid_out}, 64'd1);
    chk("post_rst_pc4", {32'd0, pc_somado_out}, 64'd4);
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
